// File: rtl/ss_dp_pkg.sv
// Shared definitions for the stack/data-pointer register: select encodings and default width.
package ss_dp_pkg;

   localparam int DP_WIDTH = 16;

   localparam logic [1:0] DP_SRC_ADD0 = 2'd0;
   localparam logic [1:0] DP_SRC_INC  = 2'd1;
   localparam logic [1:0] DP_SRC_DEC  = 2'd2;
   localparam logic [1:0] DP_SRC_HOLD = 2'd3;

endpackage

// File: rtl/ss_dp_offset_adder.sv
// Combinational next-pointer generator: add, add+1 or add-1 (modulo 2^WIDTH).
// The wrap output exists only when SS_DP_WRAP_FLAG_EN is defined.
module ss_dp_offset_adder
   import ss_dp_pkg::*;
#(
   parameter int WIDTH = DP_WIDTH
) (
   input  logic [WIDTH-1:0] add,
   input  logic [1:0]       dp_src,
   output logic [WIDTH-1:0] next_dp
`ifdef SS_DP_WRAP_FLAG_EN
   ,
   output logic             wrap
`endif
);

   // Hold is resolved by the register; here it simply passes add through.
   always_comb begin
      next_dp = add;
      case (dp_src)
         DP_SRC_INC: next_dp = add + WIDTH'(1);
         DP_SRC_DEC: next_dp = add - WIDTH'(1);
         default:    next_dp = add;
      endcase
   end

`ifdef SS_DP_WRAP_FLAG_EN
   always_comb begin
      wrap = ((dp_src == DP_SRC_INC) && (&add)) ||
             ((dp_src == DP_SRC_DEC) && (add == '0));
   end
`endif

endmodule

// File: rtl/ss_dp_16b.sv
// Stack/data-pointer register: loads add, add+1 or add-1 each clock, or holds.
// Optional registered wrap flag output dp_wrap when SS_DP_WRAP_FLAG_EN is defined.
module ss_dp_16b
   import ss_dp_pkg::*;
#(
   parameter int WIDTH = DP_WIDTH
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic [WIDTH-1:0] add,
   input  logic [1:0]       dp_src,
   output logic [WIDTH-1:0] dp
`ifdef SS_DP_WRAP_FLAG_EN
   ,
   output logic             dp_wrap
`endif
);

   logic [WIDTH-1:0] next_dp_p0;
`ifdef SS_DP_WRAP_FLAG_EN
   logic             wrap_p0;
`endif

   ss_dp_offset_adder #(
      .WIDTH (WIDTH)
   ) u_offset_adder (
      .add     (add),
      .dp_src  (dp_src),
      .next_dp (next_dp_p0)
`ifdef SS_DP_WRAP_FLAG_EN
      ,
      .wrap    (wrap_p0)
`endif
   );

   // Stage boundary: next pointer -> registered dp
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         dp <= '0;
      end else if (dp_src != DP_SRC_HOLD) begin
         dp <= next_dp_p0;
      end
   end

`ifdef SS_DP_WRAP_FLAG_EN
   // Wrap flag follows dp updates and holds alongside it.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         dp_wrap <= 1'b0;
      end else if (dp_src != DP_SRC_HOLD) begin
         dp_wrap <= wrap_p0;
      end
   end
`endif

endmodule

// File: tb/tb_ss_dp_16b.sv
// Directed self-checking bench for ss_dp_16b; also checks dp_wrap when SS_DP_WRAP_FLAG_EN is defined.
module tb_ss_dp_16b;

   logic        CLK = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] add = 16'h0000;
   logic [1:0]  dp_src = 2'd0;
   logic [15:0] dp;
`ifdef SS_DP_WRAP_FLAG_EN
   logic        dp_wrap;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   ss_dp_16b #(.WIDTH(16)) dut (
      .CLK     (CLK),
      .reset   (reset),
      .add     (add),
      .dp_src  (dp_src),
      .dp      (dp)
`ifdef SS_DP_WRAP_FLAG_EN
      ,
      .dp_wrap (dp_wrap)
`endif
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_dp(input string tag, input logic [15:0] exp);
      n_vec++;
      assert (dp === exp) else begin
         n_err++;
         $error("FAIL %s: dp=%h expected %h", tag, dp, exp);
      end
   endtask

   task automatic check_wrap(input string tag, input logic exp);
`ifdef SS_DP_WRAP_FLAG_EN
      n_vec++;
      assert (dp_wrap === exp) else begin
         n_err++;
         $error("FAIL %s: dp_wrap=%b expected %b", tag, dp_wrap, exp);
      end
`endif
   endtask

   initial begin
      // Asynchronous clear before the first clock edge (edge at t=5)
      add = 16'h1234; dp_src = 2'd0;
      #2 reset = 1'b0;
      #1 check_dp("async_clr", 16'h0000);
      check_wrap("async_clr_wrap", 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_dp("rst_held", 16'h0000);
      end

      reset = 1'b1; add = 16'h0001; dp_src = 2'd0;
      tick(); check_dp("load_1", 16'h0001);
      dp_src = 2'd1;
      tick(); check_dp("inc_1", 16'h0002);
      check_wrap("inc_1_wrap", 1'b0);
      dp_src = 2'd2;
      tick(); check_dp("dec_1", 16'h0000);
      check_wrap("dec_1_wrap", 1'b0);

      add = 16'h0055; dp_src = 2'd0;
      tick(); check_dp("load_55", 16'h0055);
      add = 16'hAAAA; dp_src = 2'd3;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_dp("hold_55", 16'h0055);
      end

      add = 16'hFFFF; dp_src = 2'd1;
      tick(); check_dp("inc_wrap", 16'h0000);
      check_wrap("inc_wrap_flag", 1'b1);
      add = 16'h4321; dp_src = 2'd3;
      tick(); check_dp("hold_after_wrap", 16'h0000);
      check_wrap("hold_wrap_flag", 1'b1);
      add = 16'h0000; dp_src = 2'd2;
      tick(); check_dp("dec_wrap", 16'hFFFF);
      check_wrap("dec_wrap_flag", 1'b1);
      add = 16'h1234; dp_src = 2'd0;
      tick(); check_dp("load_1234", 16'h1234);
      check_wrap("load_clears_flag", 1'b0);

      add = 16'h7FFF; dp_src = 2'd1;
      tick(); check_dp("inc_7fff", 16'h8000);
      add = 16'h8000; dp_src = 2'd2;
      tick(); check_dp("dec_8000", 16'h7FFF);
      add = 16'h00FF; dp_src = 2'd1;
      tick(); check_dp("inc_carry", 16'h0100);

      // Reset asserted between edges, then overriding a pending increment
      add = 16'h0100; dp_src = 2'd0;
      tick(); check_dp("load_100", 16'h0100);
      #2 reset = 1'b0;
      #1 check_dp("mid_rst_clr", 16'h0000);
      add = 16'h0007; dp_src = 2'd1;
      tick(); check_dp("rst_overrides", 16'h0000);
      reset = 1'b1;
      tick(); check_dp("resume_inc", 16'h0008);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ss_dp_16b.md
Name: ss_dp_16b

Overview:
- Stack/data-pointer register for the processor datapath.
- Each clock it loads a pointer value derived from the 16-bit input `add`: `add`, `add+1` or `add-1`, selected by `dp_src`. Code 3 holds the current value.
- Output `dp` feeds the memory-address mux and the pointer write-back path.

Parameters:
- WIDTH, 16, pointer and input width in bits. The module name fixes the production value at 16; other values are for reuse and test only.

Ports:
- CLK  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset. 0 clears the register immediately; 1 is normal operation.
- add  input  WIDTH  base value for the next pointer.
- dp_src  input  2  next-pointer select: 0 = add, 1 = add+1, 2 = add-1, 3 = hold.
- dp  output  WIDTH  registered pointer value.

Behaviour:
- Reset:
  - reset = 0 forces dp = 16'h0000 asynchronously, independent of CLK.
  - dp stays 0 while reset is low.
  - Release of reset is sampled at the next rising CLK edge; the first load happens on the first rising edge with reset = 1.
- Per rising CLK edge with reset = 1, dp loads:
  - dp_src = 0: add.
  - dp_src = 1: add + 1 (modulo 2^WIDTH).
  - dp_src = 2: add - 1 (modulo 2^WIDTH).
  - dp_src = 3: dp (unchanged).
- Latency: one cycle. The new dp is visible immediately after the rising edge that samples add/dp_src.
- Output path: dp is a pure register output, with no combinational path from add/dp_src to dp.
- Arithmetic: unsigned, WIDTH bits, carry/borrow discarded.
  - add = 16'hFFFF with select 1 gives 16'h0000.
  - add = 16'h0000 with select 2 gives 16'hFFFF.
- Simultaneous events: reset low overrides any dp_src/add value on the same edge.
- Reset asserted mid-sequence: dp returns to 0 at once. Operation resumes from add on the first edge after release.
- Unknown inputs: X on dp_src is not required to be handled; the bench keeps dp_src defined.

Optional Feature:
- Macro SS_DP_WRAP_FLAG_EN.
- When defined, adds output port dp_wrap (1 bit, registered, reset value 0). It is set on the same edge as the dp update and cleared on any other update. It is 1 in exactly two cases:
  - select 1 with add = all-ones (overflow).
  - select 2 with add = 0 (underflow).
- Under hold, dp_wrap also holds.
- When not defined: port absent, no extra logic, behaviour identical otherwise.

Decomposition:
- Shared package ss_dp_pkg holds:
  - localparams for dp_src encodings: DP_SRC_ADD0 = 2'd0, DP_SRC_INC = 2'd1, DP_SRC_DEC = 2'd2, DP_SRC_HOLD = 2'd3.
  - Default WIDTH = 16.
- One sub-module is natural: ss_dp_offset_adder.
  - Purely combinational.
  - Inputs: add and dp_src; outputs: next value and wrap bit.
  - Instantiated once ahead of the pointer register.

Test Plan:
- reset = 0 with add = 16'h1234 and dp_src = 0 while clocking -> dp = 0 throughout, with no clock needed for dp to clear.
- Release reset; add = 1, dp_src = 0, one edge -> dp = 1.
- Keep add = 1; dp_src = 1, one edge -> dp = 2. Then dp_src = 2, one edge -> dp = 0.
- dp = 0x0055, then dp_src = 3 with add = 0xAAAA for 3 edges -> dp stays 0x0055.
- Wrap cases:
  - add = 0xFFFF, dp_src = 1 -> dp = 0x0000 (dp_wrap = 1 if enabled).
  - add = 0x0000, dp_src = 2 -> dp = 0xFFFF (dp_wrap = 1).
- Reset mid-sequence: dp = 0x0100, assert reset between edges -> dp = 0 immediately. Release with add = 7, dp_src = 1 -> dp = 8 on the next edge.
